// File: rtl/subservient_wb_initiator.sv
// -----------------------------------------------------------------------------
// subservient_wb_initiator
//
// Single-outstanding Wishbone classic initiator. A host command (address,
// write data, byte selects, we) is turned into exactly one bus cycle. The
// result is returned on a response port. A cycle timeout guarantees that a
// response is produced even when the addressed slave never acks.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// valid and ready are both 1. A valid, once raised, is not withdrawn by this
// block until that transfer happens. The payload stays constant while valid
// is 1 and ready is 0.
//
// Ports:
//   i_wb_clk, i_wb_rst   clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_adr/dat/sel/we   host command
//   o_rsp_valid/i_rsp_ready, o_rsp_rdt, o_rsp_err   response (err = timeout)
//   o_wb_adr/dat/sel/we/cyc/stb, i_wb_rdt, i_wb_ack Wishbone classic master
//   o_dbg_state          current FSM state (0 IDLE, 1 BUS, 2 RESP)
// -----------------------------------------------------------------------------
module subservient_wb_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst,
  // host command
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [AW-1:0]     i_cmd_adr,
  input  logic [DW-1:0]     i_cmd_dat,
  input  logic [DW/8-1:0]   i_cmd_sel,
  input  logic              i_cmd_we,
  // response
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DW-1:0]     o_rsp_rdt,
  output logic              o_rsp_err,
  // wishbone
  output logic [AW-1:0]     o_wb_adr,
  output logic [DW-1:0]     o_wb_dat,
  output logic [DW/8-1:0]   o_wb_sel,
  output logic              o_wb_we,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  input  logic [DW-1:0]     i_wb_rdt,
  input  logic              i_wb_ack,
  // debug
  output logic [1:0]        o_dbg_state
);

  localparam int SW = DW / 8;
  // Counter holds 0..TIMEOUT-1. Keep at least one bit when the timeout is off.
  localparam int CW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   adr_q,       adr_d;
  logic [DW-1:0]   dat_q,       dat_d;
  logic [SW-1:0]   sel_q,       sel_d;
  logic            we_q,        we_d;
  logic            cyc_q,       cyc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdt_q,   rsp_rdt_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [CW-1:0]   cnt_q,       cnt_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdt_d   = rsp_rdt_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready_q is 1 throughout IDLE, so valid alone means a transfer.
        if (i_cmd_valid && cmd_ready_q) begin
          adr_d       = i_cmd_adr;
          dat_d       = i_cmd_dat;
          sel_d       = i_cmd_sel;
          we_d        = i_cmd_we;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_BUS;
        end
      end

      S_BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (i_wb_ack) begin
          cyc_d       = 1'b0;
          rsp_rdt_d   = we_q ? '0 : i_wb_rdt;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          cyc_d       = 1'b0;
          rsp_rdt_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        // Bus is idle here, so any stray ack is simply not looked at.
        if (rsp_valid_q && i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdt_d   = '0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdt_d   = '0;
      end
    endcase
  end

  // Reset also aborts an in-flight cycle; its response is never produced.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdt_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdt_q   <= rsp_rdt_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdt   = rsp_rdt_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_dbg_state = state_q;

endmodule
